// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline defines: stall vector layout, stall encodings, divide FSM
// states and the zero word used by every pipeline stage.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_t;

  // Each encoding holds the requesting stage and every stage upstream of it.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised per-stage stall vector, flush/redirect,
// and a fixed-length multi-cycle divide sequencer that holds EX while busy.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               div_start,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_busy,
  output logic               div_done
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_req;

  // A flush aborts any divide in progress, so it outranks every state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (flush_req) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            state_q <= ST_DIV;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_DIV: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign div_busy = (state_q == ST_DIV);
  assign div_done = (state_q == ST_DONE);
  assign ex_req   = stallreq_ex | div_busy;

  // Gated by rst so every output reads zero while reset is held.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = ZeroWord;
    if (rst) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (ex_req) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        div_start = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_busy;
  logic        div_done;

  int n_vec = 0;
  int n_err = 0;

  // Model: remaining busy cycles and a pending done pulse.
  int busy_left = 0;
  bit done_pend = 1'b0;

  pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .div_start    (div_start),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .div_busy     (div_busy),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_left = 0;
      done_pend = 1'b0;
    end else if (flush_req) begin
      busy_left = 0;
      done_pend = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) done_pend = 1'b1;
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else if (div_start) begin
      busy_left = DIVC;
    end
  end

  // Stall value is "hold the lowest N stages", N set by the deepest requester.
  function automatic logic [5:0] model_stall();
    int n;
    n = 0;
    if (!rst || flush_req) n = 0;
    else if (stallreq_mem) n = 5;
    else if (stallreq_ex || busy_left > 0) n = 4;
    else if (stallreq_id) n = 3;
    return 6'((1 << n) - 1);
  endfunction

  always @(negedge clk) begin
    chk("m_stall", 32'(stall), 32'(model_stall()));
    chk("m_flush", 32'(flush), 32'(rst && flush_req));
    chk("m_new_pc", new_pc, (rst && flush_req) ? flush_pc : 32'h0);
    chk("m_busy", 32'(div_busy), 32'(busy_left > 0));
    chk("m_done", 32'(div_done), 32'(done_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    div_start = 0; flush_req = 0; flush_pc = 32'h0;
  endtask

  initial begin
    // Reset held: inputs must be ignored.
    stallreq_mem = 1; flush_req = 1; flush_pc = 32'hDEAD_BEEF; div_start = 1;
    #13;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_busy", 32'(div_busy), 32'h0);
    idle_inputs();
    rst = 1;
    tick();

    stallreq_id = 1; #1;
    chk("id_only", 32'(stall), 32'h07);
    stallreq_mem = 1; #1;
    chk("id_mem", 32'(stall), 32'h1F);
    stallreq_mem = 0; stallreq_id = 0; stallreq_ex = 1; #1;
    chk("ex_only", 32'(stall), 32'h0F);
    stallreq_ex = 0;

    // Divide with a repeated start that must be ignored.
    tick();
    div_start = 1; #1;
    chk("div_c0_busy", 32'(div_busy), 32'h0);
    for (int k = 1; k <= DIVC; k++) begin
      tick();
      div_start = (k == 5) ? 1'b1 : 1'b0;
      #1;
      chk("div_busy", 32'(div_busy), 32'h1);
      chk("div_stall", 32'(stall), 32'h0F);
      chk("div_nodone", 32'(div_done), 32'h0);
    end
    tick();
    div_start = 0; #1;
    chk("c33_done", 32'(div_done), 32'h1);
    chk("c33_stall", 32'(stall), 32'h0);
    chk("c33_busy", 32'(div_busy), 32'h0);
    tick(); #1;
    chk("c34_done", 32'(div_done), 32'h0);
    chk("c34_busy", 32'(div_busy), 32'h0);

    // Flush at cycle 10 of a divide.
    tick();
    div_start = 1;
    tick();
    div_start = 0;
    for (int k = 2; k <= 10; k++) tick();
    flush_req = 1; flush_pc = 32'h0000_0020; #1;
    chk("fl_flush", 32'(flush), 32'h1);
    chk("fl_new_pc", new_pc, 32'h20);
    chk("fl_stall", 32'(stall), 32'h0);
    tick();
    flush_req = 0; flush_pc = 32'h0; #1;
    chk("fl_idle", 32'(div_busy), 32'h0);
    for (int k = 0; k < DIVC + 4; k++) begin
      tick();
      chk("fl_nodone", 32'(div_done), 32'h0);
    end

    // Flush and memory stall together; flush beats a same-cycle start.
    stallreq_mem = 1; flush_req = 1; flush_pc = 32'h1234_5678; div_start = 1; #1;
    chk("flmem_stall", 32'(stall), 32'h0);
    chk("flmem_flush", 32'(flush), 32'h1);
    tick();
    idle_inputs(); #1;
    chk("flstart_idle", 32'(div_busy), 32'h0);

    // Asynchronous reset mid-divide.
    tick();
    div_start = 1;
    tick();
    div_start = 0; stallreq_ex = 1;
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 0; #1;
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_busy", 32'(div_busy), 32'h0);
    chk("arst_done", 32'(div_done), 32'h0);
    #1 rst = 1;
    stallreq_ex = 0;
    for (int k = 0; k < DIVC + 4; k++) begin
      tick();
      chk("arst_nodone", 32'(div_done), 32'h0);
      chk("arst_nobusy", 32'(div_busy), 32'h0);
    end

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 5) == 0);
      stallreq_mem = ($urandom_range(0, 5) == 0);
      div_start    = ($urandom_range(0, 15) == 0);
      flush_req    = ($urandom_range(0, 60) == 0);
      flush_pc     = $urandom;
      if ($urandom_range(0, 700) == 0) begin
        #1 rst = 0;
        #1 rst = 1;
      end
    end
    tick();
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
